// File: rtl/mac_accum_round.sv
// Accumulates LEN signed products, then rounds half-up by SHIFT bits and saturates to OUT_W bits.
// The result is offered on a valid/ready handshake; one result per LEN accepted products.
module mac_accum_round #(
  parameter int IN_W  = 72,
  parameter int LEN   = 16,
  parameter int ACC_W = 76,
  parameter int SHIFT = 35,
  parameter int OUT_W = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             clear,
  input  logic             valid_in,
  input  logic [IN_W-1:0]  prod_in,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] result,
  output logic             sat,
  output logic             overrun
);

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int RW    = ACC_W - SHIFT + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);
  localparam logic [ACC_W:0]   HALF = (ACC_W + 1)'(1) << (SHIFT - 1);
  localparam logic signed [RW-1:0] R_MAX = {{(RW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [RW-1:0] R_MIN = {{(RW - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

  typedef enum logic [1:0] {ACC, RND, OUT} state_t;

  state_t                  state, state_nxt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] prod_ext;
  logic [CNT_W-1:0]        cnt;
  logic                    accept;
  logic [ACC_W:0]          biased;
  logic signed [RW-1:0]    shifted;
  logic [OUT_W-1:0]        rnd_val;
  logic                    rnd_sat;

  assign in_ready = !rst && ce && (state == ACC);
  assign accept   = valid_in && in_ready;
  assign prod_ext = ACC_W'($signed(prod_in));

  // One extra bit keeps the rounding bias from wrapping a near-full-scale sum.
  always_comb begin
    biased  = {acc[ACC_W-1], acc} + HALF;
    shifted = $signed(biased[ACC_W:SHIFT]);
    rnd_val = shifted[OUT_W-1:0];
    rnd_sat = 1'b0;
    if (shifted > R_MAX) begin
      rnd_val = R_MAX[OUT_W-1:0];
      rnd_sat = 1'b1;
    end else if (shifted < R_MIN) begin
      rnd_val = R_MIN[OUT_W-1:0];
      rnd_sat = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ACC;
    end else begin
      case (state)
        ACC:     if (accept && cnt == LAST) state_nxt = RND;
        RND:     if (ce) state_nxt = OUT;
        OUT:     if (ce && out_ready) state_nxt = ACC;
        default: state_nxt = ACC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACC;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      sat       <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (ce && valid_in && !in_ready) overrun <= 1'b1;
      if (clear) begin
        acc       <= '0;
        cnt       <= '0;
        out_valid <= 1'b0;
        sat       <= 1'b0;
      end else if (ce) begin
        case (state)
          ACC: begin
            if (accept) begin
              acc <= acc + prod_ext;
              cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
            end
          end
          RND: begin
            result    <= rnd_val;
            sat       <= rnd_sat;
            out_valid <= 1'b1;
          end
          OUT: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              acc       <= '0;
              cnt       <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mac_accum_round.sv
// Bench for mac_accum_round (LEN=4, SHIFT=4, OUT_W=8): directed cases plus a randomized run,
// with expected results queued at block completion and checked by an independent monitor.
module tb_mac_accum_round;
  localparam int IN_W  = 72;
  localparam int LEN   = 4;
  localparam int ACC_W = 76;
  localparam int SHIFT = 4;
  localparam int OUT_W = 8;

  logic            clk = 1'b0;
  logic            rst, ce, clear, valid_in, out_ready;
  logic [IN_W-1:0] prod_in;
  logic            in_ready, out_valid, sat, overrun;
  logic [OUT_W-1:0] result;

  typedef struct {
    logic [OUT_W-1:0] res;
    logic             s;
  } exp_t;

  exp_t   sb[$];
  longint blk[$];
  int     total = 0;
  int     bad   = 0;
  logic   rand_done = 1'b0;

  mac_accum_round #(.IN_W(IN_W), .LEN(LEN), .ACC_W(ACC_W), .SHIFT(SHIFT), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .ce(ce), .clear(clear), .valid_in(valid_in), .prod_in(prod_in),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .sat(sat), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: floor((sum + 2^(SHIFT-1)) / 2^SHIFT), then clip to the signed OUT_W range.
  function automatic exp_t model(input longint s);
    exp_t   e;
    longint div, t, q, maxv, minv;
    div  = longint'(1) << SHIFT;
    t    = s + div / 2;
    q    = t / div;
    if (t < 0 && (t % div) != 0) q = q - 1;
    maxv = (longint'(1) << (OUT_W - 1)) - 1;
    minv = -(longint'(1) << (OUT_W - 1));
    e.s  = (q > maxv) || (q < minv);
    if (q > maxv) q = maxv;
    if (q < minv) q = minv;
    e.res = OUT_W'(q);
    return e;
  endfunction

  task automatic noteAccept(input longint v);
    longint s;
    blk.push_back(v);
    if (blk.size() == LEN) begin
      s = 0;
      foreach (blk[i]) s += blk[i];
      sb.push_back(model(s));
      blk.delete();
    end
  endtask

  task automatic applyStimulus(input longint v);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checkOutput("in_ready_timeout", 0, 1);
      return;
    end
    valid_in = 1'b1;
    prod_in  = {{(IN_W - 64){v[63]}}, v};
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    noteAccept(v);
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) checkOutput("drain_timeout", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic waitOutValid();
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("out_valid_wait", out_valid, 1);
  endtask

  // Monitor: a handshake seen mid-cycle completes on the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && !clear && ce && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("result", $signed(result), $signed(e.res));
          checkOutput("sat", sat, e.s);
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    longint t2[$];
    longint v;
    rst = 1'b1; ce = 1'b1; clear = 1'b0; valid_in = 1'b0; prod_in = '0; out_ready = 1'b1;
    #12;
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_sat", sat, 0);
    checkOutput("rst_overrun", overrun, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("post_rst_in_ready", in_ready, 1);

    $display("[TB] basic block and latency");
    repeat (LEN) applyStimulus(16);
    checkOutput("lat_rnd_cycle", out_valid, 0);
    @(posedge clk); #1;
    checkOutput("lat_out_valid", out_valid, 1);
    @(posedge clk); #1;
    checkOutput("lat_one_cycle", out_valid, 0);
    checkOutput("lat_in_ready_back", in_ready, 1);
    waitDrain();

    $display("[TB] rounding and saturation");
    t2 = '{8, 0, 0, 0, -8, 0, 0, 0, 7, 0, 0, 0, -9, 0, 0, 0,
           1000, 1000, 1000, 1000, -1000, -1000, -1000, -1000, 2032, 0, 0, 0};
    foreach (t2[i]) applyStimulus(t2[i]);
    waitDrain();

    $display("[TB] clock enable stall");
    applyStimulus(5);
    applyStimulus(-3);
    ce = 1'b0;
    valid_in = 1'b1;
    prod_in = IN_W'(100);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("ce0_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    ce = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    noteAccept(100);
    applyStimulus(7);
    waitDrain();
    checkOutput("ce0_no_overrun", overrun, 0);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    repeat (LEN) applyStimulus(16);
    waitOutValid();
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_in_ready", in_ready, 0);
      checkOutput("bp_result_hold", $signed(result), 4);
      valid_in = (i == 1);
      prod_in  = IN_W'(1000);
      @(negedge clk);
    end
    valid_in = 1'b0;
    checkOutput("bp_overrun", overrun, 1);
    @(posedge clk); #1;
    ce = 1'b0;
    out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("ce0_out_valid_hold", out_valid, 1);
    end
    @(posedge clk); #1;
    ce = 1'b1;
    waitDrain();
    repeat (LEN) applyStimulus(16);
    waitDrain();

    $display("[TB] clear with pending result");
    out_ready = 1'b0;
    repeat (LEN) applyStimulus(1000);
    waitOutValid();
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    void'(sb.pop_back());
    checkOutput("clear_out_valid", out_valid, 0);
    checkOutput("clear_sat", sat, 0);
    out_ready = 1'b1;

    $display("[TB] async reset and clear mid-block");
    applyStimulus(16);
    applyStimulus(16);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_in_ready", in_ready, 0);
    checkOutput("arst_out_valid", out_valid, 0);
    checkOutput("arst_result", result, 0);
    checkOutput("arst_overrun", overrun, 0);
    blk.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) applyStimulus(16);
    clear = 1'b1;
    valid_in = 1'b1;
    prod_in = IN_W'(50);
    @(posedge clk); #1;
    clear = 1'b0;
    valid_in = 1'b0;
    blk.delete();
    repeat (LEN) applyStimulus(16);
    waitDrain();

    $display("[TB] randomized run");
    fork
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          ce = ($urandom % 4) != 0;
          out_ready = ($urandom % 3) != 0;
        end
      end
      begin
        for (int b = 0; b < 40 * LEN; b++) begin
          case ($urandom % 4)
            0:       v = longint'($urandom_range(0, 600)) - 300;
            1:       v = longint'($urandom_range(0, 40)) - 20;
            2:       v = longint'($urandom_range(0, 2000000)) - 1000000;
            default: v = longint'($urandom_range(0, 1024)) - 512;
          endcase
          applyStimulus(v);
        end
        rand_done = 1'b1;
      end
    join
    @(posedge clk); #1;
    ce = 1'b1;
    out_ready = 1'b1;
    waitDrain();
    checkOutput("sb_empty", sb.size(), 0);
    checkOutput("final_overrun", overrun, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
